muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter STEPS, default 1, meaning iteration steps per cycle; legal values 1, 2, 4.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port funct  input  6  op: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001, MTLO 010011; others ignored.
REQ-006 SHALL have port flush  input  1  abandon any in-flight operation.
REQ-007 SHALL have port operando_1  input  32  multiplicand / dividend / MTHI-MTLO data.
REQ-008 SHALL have port operando_2  input  32  multiplier / divisor.
REQ-009 SHALL have port hi  output  32  HI register; product high word or remainder.
REQ-010 SHALL have port lo  output  32  LO register; product low word or quotient.
REQ-011 SHALL have port busy  output  1  operation in flight; pipeline stalls on it.
REQ-012 SHALL have port done  output  1  one-cycle pulse when hi/lo receive a MULT/DIV result.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FIX; busy = (state != IDLE).
REQ-014 IDLE with start and MULT/MULTU/DIV/DIVU (accept edge E0): SHALL latch operands and op, convert signed operands to magnitudes, load N = 32/STEPS count, enter RUN.
REQ-015 RUN: SHALL perform STEPS shift-add (mult) or restoring shift-subtract (div) steps per edge, decrement count, enter FIX after N RUN edges.
REQ-016 FIX (edge E(N+1)): SHALL apply sign correction, write hi and lo, return to IDLE; done SHALL be high exactly during the cycle following E(N+1).
REQ-017 Latency SHALL be N+1 edges from accept to hi/lo update; busy high for N+1 cycles (33 for STEPS=1).
REQ-018 Signed correction: product negated when operand signs differ; quotient negated when signs differ; remainder takes dividend sign.
REQ-019 Divisor zero: SHALL give hi = operando_1, lo = 32'hFFFFFFFF, both signed and unsigned, normal latency.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF: SHALL give lo = 0x80000000, hi = 0.
REQ-021 IDLE with start and MTHI/MTLO: SHALL write operando_1 to hi/lo at that edge; busy and done remain 0.
REQ-022 start while busy SHALL be ignored (no queuing, no hi/lo write, no MTHI/MTLO effect).
REQ-023 flush in RUN or FIX SHALL return to IDLE next edge, leave hi/lo unchanged, suppress done; flush has priority over FIX write.
REQ-024 flush and start in IDLE same cycle: flush wins, request dropped.
REQ-025 Unlisted funct values with start SHALL cause no state change.
REQ-026 hi/lo SHALL change only at FIX, MTHI/MTLO, or reset.

Reset
REQ-027 reset SHALL set state IDLE, hi = 0, lo = 0, busy = 0, done = 0, count = 0.
REQ-028 reset SHALL override start, flush and any in-flight operation; partial result discarded, no done.

Configuration
REQ-029 Macro MULDIV_SEQUENCER_DIV_EN defined: divider datapath and DIV/DIVU compiled in per REQ-014..020.
REQ-030 Macro MULDIV_SEQUENCER_DIV_EN undefined: no divider logic; DIV/DIVU treated as unlisted funct (REQ-025); busy stays 0, hi/lo unchanged.

Verification (STEPS=1, macro defined unless noted)
REQ-031 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi 0xFFFFFFFE, lo 0x00000001, busy 33 cycles, single done pulse.
REQ-032 MULT 0xFFFFFFFD x 0x00000005 -> hi 0xFFFFFFFF, lo 0xFFFFFFF1; DIV 0xFFFFFFF9 / 2 -> lo 0xFFFFFFFD, hi 0xFFFFFFFF.
REQ-033 DIVU 0x0000000A / 0 -> hi 0x0000000A, lo 0xFFFFFFFF after 33 cycles; DIV 0x80000000 / 0xFFFFFFFF -> lo 0x80000000, hi 0.
REQ-034 MTHI 0x12345678 in IDLE -> hi 0x12345678 next edge, busy 0; MTLO issued while busy -> lo unchanged.
REQ-035 flush at RUN cycle 10 -> busy 0 next cycle, hi/lo hold prior values, no done; reset mid-RUN -> hi = lo = 0, no done.
REQ-036 Macro undefined: DIV start -> busy stays 0, hi/lo unchanged; MULTU 6 x 7 still gives lo 42.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative MIPS-style HI/LO multiply/divide unit: STEPS bits per cycle, 32/STEPS RUN cycles plus one FIX cycle.
// Divider datapath and DIV/DIVU are present only when MULDIV_SEQUENCER_DIV_EN is defined.
// start is honoured only in IDLE; flush abandons an in-flight op, and reset overrides everything.
module muldiv_sequencer #(
  parameter int STEPS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic        flush,
  input  logic [31:0] operando_1,
  input  logic [31:0] operando_2,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
`ifdef MULDIV_SEQUENCER_DIV_EN
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
`endif
  localparam logic [5:0] N_CNT   = 6'(32 / STEPS);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state_q;
  logic [5:0]  count_q;
  logic [31:0] a_q;          // multiplicand magnitude, or dividend magnitude
  logic [63:0] p_q, p_d;     // mult: {partial high, multiplier}; div: {remainder, quotient}
  logic        neg_p_q;      // negate product / quotient
  logic [31:0] hi_q, lo_q;
  logic        done_q;
  logic [32:0] add_w;
`ifdef MULDIV_SEQUENCER_DIV_EN
  logic [31:0] b_q;          // divisor magnitude
  logic        is_div_q;
  logic        neg_r_q;      // remainder follows dividend sign
  logic        div0_q;
  logic [32:0] rem_w, diff_w;
`endif

  logic        mul_go, div_go, sgn;
  logic [31:0] mag1, mag2;
  logic [63:0] prod;
  logic [31:0] res_hi, res_lo;

  // Decode the request and form operand magnitudes for signed ops.
  always_comb begin
    mul_go = (funct == F_MULT) || (funct == F_MULTU);
`ifdef MULDIV_SEQUENCER_DIV_EN
    div_go = (funct == F_DIV) || (funct == F_DIVU);
`else
    div_go = 1'b0;
`endif
    sgn  = ~funct[0];
    mag1 = (sgn && operando_1[31]) ? (32'd0 - operando_1) : operando_1;
    mag2 = (sgn && operando_2[31]) ? (32'd0 - operando_2) : operando_2;
  end

  // STEPS iterations of shift-add multiply or restoring shift-subtract divide.
  always_comb begin
    p_d   = p_q;
    add_w = '0;
`ifdef MULDIV_SEQUENCER_DIV_EN
    rem_w  = '0;
    diff_w = '0;
`endif
    for (int s = 0; s < STEPS; s++) begin
`ifdef MULDIV_SEQUENCER_DIV_EN
      if (is_div_q) begin
        rem_w  = p_d[63:31];
        diff_w = rem_w - {1'b0, b_q};
        if (!diff_w[32]) p_d = {diff_w[31:0], p_d[30:0], 1'b1};
        else             p_d = {rem_w[31:0],  p_d[30:0], 1'b0};
      end else
`endif
      begin
        add_w = {1'b0, p_d[63:32]} + (p_d[0] ? {1'b0, a_q} : 33'd0);
        p_d   = {add_w, p_d[31:1]};
      end
    end
  end

  // Sign correction and divide-by-zero result applied at FIX.
  always_comb begin
    prod   = neg_p_q ? (64'd0 - p_q) : p_q;
    res_hi = prod[63:32];
    res_lo = prod[31:0];
`ifdef MULDIV_SEQUENCER_DIV_EN
    if (is_div_q) begin
      if (div0_q) begin
        res_hi = neg_r_q ? (32'd0 - a_q) : a_q;  // rebuilds the original dividend
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = neg_r_q ? (32'd0 - p_q[63:32]) : p_q[63:32];
        res_lo = neg_p_q ? (32'd0 - p_q[31:0])  : p_q[31:0];
      end
    end
`endif
  end

  // Sequencer FSM: accept in IDLE, iterate in RUN, write HI/LO in FIX.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      a_q      <= '0;
      p_q      <= '0;
      neg_p_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
`ifdef MULDIV_SEQUENCER_DIV_EN
      b_q      <= '0;
      is_div_q <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !flush) begin
            if (mul_go || div_go) begin
              state_q <= RUN;
              count_q <= N_CNT;
              a_q     <= mag1;
              p_q     <= {32'd0, (div_go ? mag1 : mag2)};
              neg_p_q <= sgn && (operando_1[31] ^ operando_2[31]);
`ifdef MULDIV_SEQUENCER_DIV_EN
              b_q      <= mag2;
              is_div_q <= div_go;
              neg_r_q  <= sgn && operando_1[31];
              div0_q   <= (operando_2 == 32'd0);
`endif
            end else if (funct == F_MTHI) begin
              hi_q <= operando_1;
            end else if (funct == F_MTLO) begin
              lo_q <= operando_1;
            end
          end
        end
        RUN: begin
          if (flush) begin
            state_q <= IDLE;
            count_q <= '0;
          end else begin
            p_q     <= p_d;
            count_q <= count_q - 6'd1;
            if (count_q == 6'd1) state_q <= FIX;
          end
        end
        FIX: begin
          state_q <= IDLE;
          if (!flush) begin
            hi_q   <= res_hi;
            lo_q   <= res_lo;
            done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: fixed vectors, corner sequences, randomized ops vs. arithmetic model.
// DIV/DIVU expectations depend on MULDIV_SEQUENCER_DIV_EN being defined for the build.
// All waits are bounded by fixed cycle windows.
module tb_muldiv_sequencer;

  localparam int STEPS = 1;
  localparam int LAT   = 32 / STEPS + 1;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_BAD   = 6'b101010;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [5:0]  funct;
  logic [31:0] op1, op2;
  logic [31:0] hi, lo;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.STEPS(STEPS)) dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct), .flush(flush),
    .operando_1(op1), .operando_2(op2), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          bc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request, then observe a window covering the full latency plus margin.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] rhi, output logic [31:0] rlo,
                       output int bc, output int dc);
    @(negedge clk);
    start = 1'b1; funct = f; op1 = a; op2 = b;
    @(posedge clk); #1;
    start = 1'b0; funct = 6'd0; op1 = 32'd0; op2 = 32'd0;
    bc = 0; dc = 0;
    for (int k = 0; k < LAT + 6; k++) begin
      if (busy) bc++;
      if (done) dc++;
      @(posedge clk); #1;
    end
    rhi = hi; rlo = lo;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Reference: plain 64-bit / signed arithmetic on the architectural rules.
  task automatic ref_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] hi_in, input logic [31:0] lo_in,
                           output logic [31:0] ho, output logic [31:0] lo_o, output int bc);
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic signed [31:0] sa, sb;
    ho = hi_in; lo_o = lo_in; bc = 0;
    sa = a; sb = b;
    case (f)
      F_MULT: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        {ho, lo_o} = sp; bc = LAT;
      end
      F_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        {ho, lo_o} = up; bc = LAT;
      end
      F_MTHI: ho = a;
      F_MTLO: lo_o = a;
`ifdef MULDIV_SEQUENCER_DIV_EN
      F_DIV: begin
        bc = LAT;
        if (b == 32'd0) begin ho = a; lo_o = 32'hFFFF_FFFF; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin ho = 32'd0; lo_o = 32'h8000_0000; end
        else begin lo_o = sa / sb; ho = sa % sb; end
      end
      F_DIVU: begin
        bc = LAT;
        if (b == 32'd0) begin ho = a; lo_o = 32'hFFFF_FFFF; end
        else begin lo_o = a / b; ho = a % b; end
      end
`endif
      default: ;
    endcase
  endtask

  initial begin
    logic [31:0] rh, rl, mh, ml, eh, el, a, b;
    logic [5:0]  f;
    int          bc, dc, ebc, nv;
    vec_t        tbl[10];

    reset = 1'b1; start = 1'b0; flush = 1'b0; funct = 6'd0; op1 = 32'd0; op2 = 32'd0;

    nv = 0;
    tbl[nv++] = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, LAT};
    tbl[nv++] = '{F_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, LAT};
    tbl[nv++] = '{F_MULTU, 32'h0000_0006, 32'h0000_0007, 32'h0000_0000, 32'h0000_002A, LAT};
    tbl[nv++] = '{F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, LAT};
`ifdef MULDIV_SEQUENCER_DIV_EN
    tbl[nv++] = '{F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT};
    tbl[nv++] = '{F_DIVU,  32'h0000_000A, 32'h0000_0000, 32'h0000_000A, 32'hFFFF_FFFF, LAT};
    tbl[nv++] = '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, LAT};
    tbl[nv++] = '{F_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, LAT};
    tbl[nv++] = '{F_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, LAT};
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);

    // Vector table
    for (int i = 0; i < nv; i++) begin
      issue(tbl[i].f, tbl[i].a, tbl[i].b, rh, rl, bc, dc);
      chk($sformatf("vec%0d hi", i), rh, tbl[i].hi);
      chk($sformatf("vec%0d lo", i), rl, tbl[i].lo);
      chk($sformatf("vec%0d busy_cycles", i), 32'(bc), 32'(tbl[i].bc));
      chk($sformatf("vec%0d done_pulses", i), 32'(dc), 32'd1);
    end

    // MTHI / MTLO in IDLE take effect at the accepting edge, no busy
    @(negedge clk); start = 1'b1; funct = F_MTHI; op1 = 32'h1234_5678;
    @(posedge clk); #1; start = 1'b0;
    chk("mthi hi", hi, 32'h1234_5678);
    chk("mthi busy", 32'(busy), 32'd0);
    chk("mthi done", 32'(done), 32'd0);
    @(negedge clk); start = 1'b1; funct = F_MTLO; op1 = 32'h8765_4321;
    @(posedge clk); #1; start = 1'b0;
    chk("mtlo lo", lo, 32'h8765_4321);

    // flush + start in IDLE: request dropped
    @(negedge clk); start = 1'b1; flush = 1'b1; funct = F_MTHI; op1 = 32'h1111_1111;
    @(posedge clk); #1;
    chk("flush+mthi hi", hi, 32'h1234_5678);
    @(negedge clk); funct = F_MULTU; op1 = 32'd3; op2 = 32'd4;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    chk("flush+start busy", 32'(busy), 32'd0);

    // Unlisted funct: no effect
    issue(F_BAD, 32'hDEAD_BEEF, 32'd1, rh, rl, bc, dc);
    chk("bad funct busy", 32'(bc), 32'd0);
    chk("bad funct hi", rh, 32'h1234_5678);
    chk("bad funct lo", rl, 32'h8765_4321);

`ifndef MULDIV_SEQUENCER_DIV_EN
    issue(F_DIV, 32'd100, 32'd7, rh, rl, bc, dc);
    chk("div disabled busy", 32'(bc), 32'd0);
    chk("div disabled hi", rh, 32'h1234_5678);
    chk("div disabled lo", rl, 32'h8765_4321);
`endif

    // MTLO while busy is ignored; hi/lo hold until FIX
    @(negedge clk); start = 1'b1; funct = F_MULTU; op1 = 32'd6; op2 = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); start = 1'b1; funct = F_MTLO; op1 = 32'hDEAD_BEEF;
    @(posedge clk); #1; start = 1'b0;
    chk("busy mtlo lo hold", lo, 32'h8765_4321);
    chk("busy mid hi hold", hi, 32'h1234_5678);
    dc = 0;
    for (int k = 0; k < LAT + 4; k++) begin
      if (done) dc++;
      @(posedge clk); #1;
    end
    chk("busy mtlo final lo", lo, 32'd42);
    chk("busy mtlo final hi", hi, 32'd0);
    chk("busy mtlo done", 32'(dc), 32'd1);

    // flush at RUN cycle 10
    issue(F_MTHI, 32'hAAAA_5555, 32'd0, rh, rl, bc, dc);
    issue(F_MTLO, 32'h5555_AAAA, 32'd0, rh, rl, bc, dc);
    @(negedge clk); start = 1'b1; funct = F_MULTU; op1 = 32'd3; op2 = 32'd4;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush busy", 32'(busy), 32'd0);
    dc = 0;
    for (int k = 0; k < LAT + 4; k++) begin
      if (done) dc++;
      @(posedge clk); #1;
    end
    chk("flush done", 32'(dc), 32'd0);
    chk("flush hi", hi, 32'hAAAA_5555);
    chk("flush lo", lo, 32'h5555_AAAA);

    // reset mid-RUN
    @(negedge clk); start = 1'b1; funct = F_MULT; op1 = 32'd9; op2 = 32'd9;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("rst mid hi", hi, 32'd0);
    chk("rst mid lo", lo, 32'd0);
    chk("rst mid busy", 32'(busy), 32'd0);
    @(negedge clk); reset = 1'b0;
    dc = 0;
    for (int k = 0; k < LAT + 4; k++) begin
      if (done) dc++;
      @(posedge clk); #1;
    end
    chk("rst mid done", 32'(dc), 32'd0);

    // Randomized ops against the reference model
    do_reset();
    mh = 32'd0; ml = 32'd0;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: f = F_MULT;
        3, 4:    f = F_MULTU;
        5:       f = F_DIV;
        6:       f = F_DIVU;
        7:       f = F_MTHI;
        8:       f = F_MTLO;
        default: f = F_BAD;
      endcase
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 20));
        2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: b = $urandom;
      endcase
      ref_model(f, a, b, mh, ml, eh, el, ebc);
      issue(f, a, b, rh, rl, bc, dc);
      chk($sformatf("rnd%0d f=%b hi", i, f), rh, eh);
      chk($sformatf("rnd%0d f=%b lo", i, f), rl, el);
      chk($sformatf("rnd%0d busy_cycles", i), 32'(bc), 32'(ebc));
      chk($sformatf("rnd%0d done_pulses", i), 32'(dc), (ebc != 0) ? 32'd1 : 32'd0);
      mh = eh; ml = el;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
